uart_status_reporter: RTL and testbench

//  Transmit-side counterpart of the UART command path. On request, snapshots the five synth

---
 rtl/uart_status_reporter.sv | 218 +++++++++++++++++++++
 tb/tb_uart_status_reporter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_reporter.sv
// Snapshots the five synth parameters on request and streams them out as ASCII
// command records (header letter + 8 uppercase hex digits), optionally ending in CR LF.
module uart_status_reporter #(
    parameter bit SEND_CRLF   = 1'b1,
    parameter bit AUTO_REPORT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        report_req,
    input  logic        update_tick,
    input  logic [31:0] phase_inc,
    input  logic [15:0] amplitude,
    input  logic [1:0]  wave_select,
    input  logic [31:0] mod_phase_inc,
    input  logic [15:0] mod_depth,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        report_done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_HEX  = 3'd2;
    localparam logic [2:0] ST_CR   = 3'd3;
    localparam logic [2:0] ST_LF   = 3'd4;

    localparam logic [2:0] LAST_REC = 3'd4;
    localparam logic [2:0] LAST_NIB = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [2:0]  rec_idx_q, rec_idx_d;
    logic [2:0]  nib_idx_q, nib_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pending_q, pending_d;

    logic [31:0] snap_f_q, snap_f_d;
    logic [15:0] snap_a_q, snap_a_d;
    logic [1:0]  snap_w_q, snap_w_d;
    logic [31:0] snap_m_q, snap_m_d;
    logic [15:0] snap_d_q, snap_d_d;

    logic        request;
    logic        handshake;
    logic [31:0] cur_word;
    logic [2:0]  next_nib;
    logic [2:0]  next_rec;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

    function automatic logic [7:0] header_ascii(input logic [2:0] rec);
        case (rec)
            3'd0:    header_ascii = 8'h46;
            3'd1:    header_ascii = 8'h41;
            3'd2:    header_ascii = 8'h57;
            3'd3:    header_ascii = 8'h4D;
            default: header_ascii = 8'h44;
        endcase
    endfunction

    function automatic logic [3:0] nibble_of(input logic [31:0] word, input logic [2:0] idx);
        logic [4:0] base;
        base      = {LAST_NIB - idx, 2'b00};
        nibble_of = word[base +: 4];
    endfunction

    assign request   = report_req | (AUTO_REPORT & update_tick);
    assign handshake = tx_valid_q & tx_ready;
    assign next_nib  = nib_idx_q + 3'd1;
    assign next_rec  = rec_idx_q + 3'd1;

    // Padding lines the fields up where the command parser extracts them,
    // so a read-back record can be replayed verbatim.
    always_comb begin
        cur_word = 32'h0;
        case (rec_idx_q)
            3'd0:    cur_word = snap_f_q;
            3'd1:    cur_word = {12'h000, snap_a_q, 4'h0};
            3'd2:    cur_word = {24'h000000, 2'b00, snap_w_q, 4'h0};
            3'd3:    cur_word = snap_m_q;
            default: cur_word = {12'h000, snap_d_q, 4'h0};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rec_idx_d  = rec_idx_q;
        nib_idx_d  = nib_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pending_d  = pending_q;
        snap_f_d   = snap_f_q;
        snap_a_d   = snap_a_q;
        snap_w_d   = snap_w_q;
        snap_m_d   = snap_m_q;
        snap_d_d   = snap_d_q;

        // busy_q is still high on the final-handshake edge, so a request there queues.
        if (busy_q && request) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (request || pending_q) begin
                    snap_f_d   = phase_inc;
                    snap_a_d   = amplitude;
                    snap_w_d   = wave_select;
                    snap_m_d   = mod_phase_inc;
                    snap_d_d   = mod_depth;
                    pending_d  = 1'b0;
                    state_d    = ST_HDR;
                    rec_idx_d  = 3'd0;
                    nib_idx_d  = 3'd0;
                    tx_data_d  = header_ascii(3'd0);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_HDR: begin
                if (handshake) begin
                    state_d   = ST_HEX;
                    nib_idx_d = 3'd0;
                    tx_data_d = hex_ascii(nibble_of(cur_word, 3'd0));
                end
            end
            ST_HEX: begin
                if (handshake) begin
                    if (nib_idx_q != LAST_NIB) begin
                        nib_idx_d = next_nib;
                        tx_data_d = hex_ascii(nibble_of(cur_word, next_nib));
                    end else if (rec_idx_q != LAST_REC) begin
                        state_d   = ST_HDR;
                        rec_idx_d = next_rec;
                        tx_data_d = header_ascii(next_rec);
                    end else if (SEND_CRLF) begin
                        state_d   = ST_CR;
                        tx_data_d = 8'h0D;
                    end else begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (handshake) begin
                    state_d   = ST_LF;
                    tx_data_d = 8'h0A;
                end
            end
            ST_LF: begin
                if (handshake) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rec_idx_q  <= 3'd0;
            nib_idx_q  <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            snap_f_q   <= 32'h0;
            snap_a_q   <= 16'h0;
            snap_w_q   <= 2'b00;
            snap_m_q   <= 32'h0;
            snap_d_q   <= 16'h0;
        end else begin
            state_q    <= state_d;
            rec_idx_q  <= rec_idx_d;
            nib_idx_q  <= nib_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            snap_f_q   <= snap_f_d;
            snap_a_q   <= snap_a_d;
            snap_w_q   <= snap_w_d;
            snap_m_q   <= snap_m_d;
            snap_d_q   <= snap_d_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign report_done = done_q;

endmodule

// File: tb/tb_uart_status_reporter.sv
// Directed bench for uart_status_reporter: a default instance plus an
// AUTO_REPORT=1 / SEND_CRLF=0 instance sharing the same stimulus.
module tb_uart_status_reporter;

    logic        clk;
    logic        reset_n;
    logic        report_req;
    logic        update_tick;
    logic [31:0] phase_inc;
    logic [15:0] amplitude;
    logic [1:0]  wave_select;
    logic [31:0] mod_phase_inc;
    logic [15:0] mod_depth;
    logic        tx_ready;

    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        busy0, busy1;
    logic        done0, done1;

    logic        sel;
    logic [7:0]  mon_data;
    logic        mon_valid, mon_busy, mon_done;

    int chk_cnt = 0;
    int err_cnt = 0;

    localparam string EXP_T1  = "F000049D2A000FFFF0W00000000M000000D7D00002000\r\n";
    localparam string EXP_T3B = "FDEADBEEFA000FFFF0W00000000M000000D7D00002000\r\n";
    localparam string EXP_T5  = "F000049D2A000FFFF0W00000030M000000D7D00002000";

    uart_status_reporter #(.SEND_CRLF(1'b1), .AUTO_REPORT(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .report_req(report_req), .update_tick(update_tick),
        .phase_inc(phase_inc), .amplitude(amplitude), .wave_select(wave_select),
        .mod_phase_inc(mod_phase_inc), .mod_depth(mod_depth),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .report_done(done0)
    );

    uart_status_reporter #(.SEND_CRLF(1'b0), .AUTO_REPORT(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .report_req(report_req), .update_tick(update_tick),
        .phase_inc(phase_inc), .amplitude(amplitude), .wave_select(wave_select),
        .mod_phase_inc(mod_phase_inc), .mod_depth(mod_depth),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .report_done(done1)
    );

    assign mon_data  = sel ? tx_data1  : tx_data0;
    assign mon_valid = sel ? tx_valid1 : tx_valid0;
    assign mon_busy  = sel ? busy1     : busy0;
    assign mon_done  = sel ? done1     : done0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Collects one report from the selected instance and compares it byte by byte.
    // chg_idx: after that many bytes, phase_inc is rewritten; burst: extra requests mid-report.
    task automatic run_report(input string tag, input string exp, input bit rnd,
                              input int chg_idx, input bit burst,
                              output int cycles, output int first_cyc);
        int         idx     = 0;
        int         cyc     = 0;
        bit         stalled = 0;
        logic [7:0] held    = 8'h00;
        first_cyc = 0;
        while (idx < exp.len() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            report_req  = 1'b0;
            update_tick = 1'b0;
            if (stalled) check_val($sformatf("%s_stable%0d", tag, idx), {24'h0, mon_data}, {24'h0, held});
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mon_valid) begin
                if (first_cyc == 0) begin
                    first_cyc = cyc;
                    check_val({tag, "_busy"}, {31'h0, mon_busy}, 32'h1);
                end
                if (tx_ready) begin
                    check_val($sformatf("%s_byte%0d", tag, idx), {24'h0, mon_data}, {24'h0, exp[idx]});
                    if (burst && (idx == 5 || idx == 20 || idx == exp.len() - 1)) report_req = 1'b1;
                    idx++;
                    stalled = 0;
                    if (idx == chg_idx) phase_inc = 32'hDEADBEEF;
                end else begin
                    held    = mon_data;
                    stalled = 1;
                end
            end else if (first_cyc != 0) begin
                check_val($sformatf("%s_valid_gap%0d", tag, idx), {31'h0, mon_valid}, 32'h1);
            end
        end
        cycles = cyc - first_cyc + 1;
        if (idx < exp.len()) check_val({tag, "_timeout_bytes"}, idx, exp.len());
        tx_ready = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
        check_val({tag, "_done"},      {31'h0, mon_done},  32'h1);
        check_val({tag, "_end_valid"}, {31'h0, mon_valid}, 32'h0);
        check_val({tag, "_end_busy"},  {31'h0, mon_busy},  32'h0);
        $display("report %s: %0d bytes received, %0d cycles", tag, idx, cycles);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        report_req = 1'b1;
    endtask

    initial begin
        int cycles, first_cyc, n, guard;
        reset_n = 1'b0; report_req = 1'b0; update_tick = 1'b0; tx_ready = 1'b1; sel = 1'b0;
        phase_inc = 32'h49D2; amplitude = 16'hFFFF; wave_select = 2'b00;
        mod_phase_inc = 32'hD7; mod_depth = 16'h0200;
        repeat (3) @(negedge clk);
        check_val("rst_valid", {31'h0, tx_valid0}, 32'h0);
        check_val("rst_data",  {24'h0, tx_data0},  32'h0);
        check_val("rst_busy",  {31'h0, busy0},     32'h0);
        check_val("rst_done",  {31'h0, done0},     32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_valid", {31'h0, tx_valid0}, 32'h0);

        // T1: back-to-back stream, exactly one done pulse
        pulse_req();
        run_report("T1", EXP_T1, 1'b0, -1, 1'b0, cycles, first_cyc);
        check_val("T1_cycles", cycles, 47);
        @(negedge clk);
        check_val("T1_done_one_cycle", {31'h0, done0}, 32'h0);

        // T2: random backpressure
        pulse_req();
        run_report("T2", EXP_T1, 1'b1, -1, 1'b0, cycles, first_cyc);

        // T3: input change mid-report is not seen until the next report
        repeat (3) @(negedge clk);
        pulse_req();
        run_report("T3a", EXP_T1, 1'b0, 3, 1'b0, cycles, first_cyc);
        pulse_req();
        run_report("T3b", EXP_T3B, 1'b0, -1, 1'b0, cycles, first_cyc);
        phase_inc = 32'h49D2;

        // T4: three requests (last on the final handshake) merge into one extra report
        repeat (3) @(negedge clk);
        pulse_req();
        run_report("T4a", EXP_T1, 1'b0, -1, 1'b1, cycles, first_cyc);
        run_report("T4b", EXP_T1, 1'b0, -1, 1'b0, cycles, first_cyc);
        check_val("T4_one_idle_cycle", first_cyc, 1);
        repeat (6) @(negedge clk);
        check_val("T4_no_third_valid", {31'h0, tx_valid0}, 32'h0);
        check_val("T4_no_third_busy",  {31'h0, busy0},     32'h0);

        // T5: update_tick only starts the AUTO_REPORT instance
        guard = 0;
        while (busy1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("T5_dut1_idle", {31'h0, busy1}, 32'h0);
        wave_select = 2'b11;
        sel = 1'b1;
        @(negedge clk);
        update_tick = 1'b1;
        run_report("T5", EXP_T5, 1'b0, -1, 1'b0, cycles, first_cyc);
        check_val("T5_cycles", cycles, 45);
        check_val("T5_dut0_busy",  {31'h0, busy0},     32'h0);
        check_val("T5_dut0_valid", {31'h0, tx_valid0}, 32'h0);
        sel = 1'b0;
        wave_select = 2'b00;

        // T6: reset during the 4th hex digit of 'M', with a pending request queued
        repeat (3) @(negedge clk);
        pulse_req();
        n = 0;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            report_req = (n == 10);
            if (tx_valid0) begin
                if (n == 31) break;
                n++;
            end
        end
        check_val("T6_reached_byte31", n, 31);
        check_val("T6_byte31", {24'h0, tx_data0}, 32'h30);
        reset_n = 1'b0;
        report_req = 1'b0;
        #1;
        check_val("T6_valid_async", {31'h0, tx_valid0}, 32'h0);
        check_val("T6_busy_async",  {31'h0, busy0},     32'h0);
        check_val("T6_data_async",  {24'h0, tx_data0},  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("T6_idle_valid", {31'h0, tx_valid0}, 32'h0);
        check_val("T6_idle_busy",  {31'h0, busy0},     32'h0);
        pulse_req();
        run_report("T6b", EXP_T1, 1'b0, -1, 1'b0, cycles, first_cyc);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
